// File: rtl/loader_pkg.sv
// Shared definitions for the IMEM program loader: FSM encoding, word and header sizes.
`default_nettype none

package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERROR = 3'd6
   } state_e;

   localparam int WORD_W         = 32;
   localparam int HDR_LEN        = 2;
   localparam int BYTES_PER_WORD = WORD_W / 8;

   function automatic logic takes_bytes(input state_e s);
      return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words; pulses when a word completes.
`default_nettype none

module imem_word_packer
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              valid_i,
   input  logic [7:0]        byte_i,
   output logic              word_done_o,
   output logic [WORD_W-1:0] word_o
);

   logic [1:0]        cnt_q;
   logic [WORD_W-1:0] word_q;
   logic [WORD_W-1:0] word_d;

   // The completed word includes the byte arriving this cycle, so the
   // writer can register it on the same edge that accepts the 4th byte.
   always_comb begin
      word_d                 = word_q;
      word_d[8*cnt_q +: 8]   = byte_i;
   end

   assign word_o      = word_d;
   assign word_done_o = valid_i && (cnt_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         word_q <= '0;
      end else if (clear_i) begin
         cnt_q  <= 2'd0;
         word_q <= '0;
      end else if (valid_i) begin
         cnt_q  <= cnt_q + 2'd1;
         word_q <= word_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// Loads instruction memory from a framed byte stream (length, payload, XOR checksum)
// and holds the CPU in reset until a load finishes with a matching checksum.
`default_nettype none

module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   output logic              in_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [WORD_W-1:0] imem_wdata_o,
   output logic              cpu_hold_o,
   output logic              done_o,
   output logic              error_o
);

   localparam int               CAP_WORDS = 1 << ADDR_W;
   localparam logic [ADDR_W:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [7:0]          len_lo_q;
   logic [ADDR_W:0]     total_q;
   logic [ADDR_W:0]     word_cnt_q;
   logic [7:0]          xor_q;
   logic                in_ready_q;
   logic                imem_we_q;
   logic [ADDR_W-1:0]   imem_addr_q;
   logic [WORD_W-1:0]   imem_wdata_q;
   logic                cpu_hold_q;
   logic                done_q;
   logic                error_q;

   logic                   w_accept;
   logic                   w_start_load;
   logic                   w_data_acc;
   logic                   w_word_done;
   logic [WORD_W-1:0]      w_word;
   logic [8*HDR_LEN-1:0]   w_len;
   logic                   w_last_word;

   assign w_accept     = in_valid_i && in_ready_q;
   assign w_start_load = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                     (state_q == ST_ERROR));
   assign w_data_acc   = w_accept && (state_q == ST_DATA);
   assign w_len        = {in_data_i, len_lo_q};
   assign w_last_word  = ((word_cnt_q + CNT_ONE) == total_q);

   imem_word_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (w_start_load),
      .valid_i     (w_data_acc),
      .byte_i      (in_data_i),
      .word_done_o (w_word_done),
      .word_o      (w_word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (w_start_load) state_d = ST_LEN0;
         end
         ST_LEN0: begin
            if (w_accept) state_d = ST_LEN1;
         end
         ST_LEN1: begin
            if (w_accept) begin
               if (32'(w_len) > CAP_WORDS) state_d = ST_ERROR;
               else if (w_len == '0)       state_d = ST_CSUM;
               else                        state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_word_done && w_last_word) state_d = ST_CSUM;
         end
         ST_CSUM: begin
            if (w_accept) state_d = (in_data_i == xor_q) ? ST_DONE : ST_ERROR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         len_lo_q     <= '0;
         total_q      <= '0;
         word_cnt_q   <= '0;
         xor_q        <= '0;
         in_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= takes_bytes(state_d);
         cpu_hold_q <= (state_d != ST_DONE);
         done_q     <= (state_d == ST_DONE);
         error_q    <= (state_d == ST_ERROR);
         imem_we_q  <= w_word_done;

         if (w_start_load) begin
            word_cnt_q <= '0;
            xor_q      <= '0;
            total_q    <= '0;
         end
         if (w_accept && (state_q == ST_LEN0)) len_lo_q <= in_data_i;
         if (w_accept && (state_q == ST_LEN1)) total_q  <= w_len[ADDR_W:0];
         if (w_data_acc) xor_q <= xor_q ^ in_data_i;
         if (w_word_done) begin
            imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
            imem_wdata_q <= w_word;
            word_cnt_q   <= word_cnt_q + CNT_ONE;
         end
      end
   end

   assign in_ready_o   = in_ready_q;
   assign imem_we_o    = imem_we_q;
   assign imem_addr_o  = imem_addr_q;
   assign imem_wdata_o = imem_wdata_q;
   assign cpu_hold_o   = cpu_hold_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a frame-level reference model and write scoreboard.
`default_nettype none

module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .in_valid_i   (in_valid),
      .in_data_i    (in_data),
      .in_ready_o   (in_ready),
      .imem_we_o    (imem_we),
      .imem_addr_o  (imem_addr),
      .imem_wdata_o (imem_wdata),
      .cpu_hold_o   (cpu_hold),
      .done_o       (done),
      .error_o      (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   int              n_chk = 0;
   int              n_pass = 0;
   int              wr_cnt = 0;
   int              since_wr = 100;
   logic [7:0]      last_addr = 8'h00;
   logic [31:0]     last_data = 32'h0;
   wr_t             exp_q[$];
   logic [7:0]      pl_q[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   // Per-cycle compare: reset values, status invariants, and every write against the model queue.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_outputs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error},
               {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0});
      end else begin
         check("hold_iff_not_done", cpu_hold, !done);
         check("done_error_exclusive", done && error, 1'b0);
         if (imem_we) begin
            wr_cnt++;
            check("write_spacing", since_wr >= 3, 1'b1);
            since_wr  = 0;
            last_addr = imem_addr;
            last_data = imem_wdata;
            check("write_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", imem_addr, e.a);
               check("wr_data", imem_wdata, e.d);
            end
         end else begin
            since_wr++;
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Presents one byte from a negedge and returns at the negedge after it is accepted.
   task automatic send_byte(input logic [7:0] b, input bit rnd, input bit with_start);
      int t;
      if (rnd) while ($urandom_range(0, 1) == 1) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (with_start) start = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("ready_timeout", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // Frame-level model: words are little-endian groups of 4 payload bytes, written to
   // address i; status is DONE iff the checksum byte equals the XOR of the payload.
   task automatic run_frame(input logic [7:0] lo, input logic [7:0] hi, input int csum_ovr,
                            input bit corrupt, input bit rnd, input bit start_at_csum);
      int          n;
      int          w0;
      logic [7:0]  x;
      logic [7:0]  cs;
      logic [31:0] w;
      wr_t         e;
      n  = int'({hi, lo});
      w0 = wr_cnt;
      x  = 8'h00;
      w  = 32'h0;
      if (n <= 256) begin
         for (int i = 0; i < 4 * n; i++) begin
            x = x ^ pl_q[i];
            w[8*(i%4) +: 8] = pl_q[i];
            if (i % 4 == 3) begin
               e.a = 8'(i / 4);
               e.d = w;
               exp_q.push_back(e);
            end
         end
      end
      pulse_start();
      send_byte(lo, rnd, 1'b0);
      send_byte(hi, rnd, 1'b0);
      if (n > 256) begin
         check("oversize_status", {done, error, cpu_hold, in_ready}, 4'b0110);
         repeat (4) @(negedge clk);
         check("oversize_no_write", wr_cnt - w0, 0);
         pl_q.delete();
         return;
      end
      for (int i = 0; i < 4 * n; i++) begin
         send_byte(pl_q[i], rnd, 1'b0);
         if (i % 4 == 3) check("we_after_4th_byte", imem_we, 1'b1);
         else            check("we_quiet", imem_we, 1'b0);
      end
      cs = (csum_ovr >= 0) ? 8'(csum_ovr) : (x ^ {7'b0, corrupt});
      send_byte(cs, rnd, start_at_csum);
      if (cs == x) check("good_status", {done, error, cpu_hold, in_ready}, 4'b1000);
      else         check("bad_status",  {done, error, cpu_hold, in_ready}, 4'b0110);
      check("write_count", wr_cnt - w0, n);
      check("writes_drained", exp_q.size(), 0);
      pl_q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Bytes without a start must not be taken.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (5) begin
         @(negedge clk);
         check("no_start_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;

      // Directed two-word frame; XOR of 11..88 is 0x88.
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(8'h02, 8'h00, 8'h88, 1'b0, 1'b0, 1'b0);
      check("dir_last_addr", last_addr, 8'h01);
      check("dir_last_data", last_data, 32'h88776655);
      check("dir_done", {done, cpu_hold}, 2'b10);

      // Same frame with a wrong checksum, then a clean reload out of ERROR.
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(8'h02, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
      check("bad_error", {done, error, cpu_hold}, 3'b011);
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(8'h02, 8'h00, -1, 1'b0, 1'b0, 1'b0);
      check("reload_done", {done, error}, 2'b10);

      // N = 257 is rejected right after the header.
      run_frame(8'h01, 8'h01, -1, 1'b0, 1'b0, 1'b0);
      check("oversize_error", error, 1'b1);

      // N = 256 fills the whole memory.
      for (int i = 0; i < 1024; i++) pl_q.push_back(8'($urandom));
      run_frame(8'h00, 8'h01, -1, 1'b0, 1'b0, 1'b0);
      check("full_last_addr", last_addr, 8'hFF);
      check("full_done", done, 1'b1);

      // Empty program.
      run_frame(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      check("empty_done", done, 1'b1);

      // Stalled stream, with a start colliding with the checksum byte.
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(8'h02, 8'h00, -1, 1'b0, 1'b1, 1'b1);
      check("stall_last_data", last_data, 32'h88776655);
      check("start_ignored_in_csum", in_ready, 1'b0);

      // Reset in the middle of the second word.
      begin
         wr_t e;
         e.a = 8'h00;
         e.d = 32'h44332211;
         exp_q.push_back(e);
      end
      pulse_start();
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      send_byte(8'h33, 1'b0, 1'b0);
      send_byte(8'h44, 1'b0, 1'b0);
      send_byte(8'h55, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_word0_written", last_data, 32'h44332211);
      check("rst_queue_empty", exp_q.size(), 0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_back_idle", {in_ready, cpu_hold}, 2'b01);

      // Randomized frames.
      for (int k = 0; k < 10; k++) begin
         int  n;
         bit  bad;
         n   = $urandom_range(0, 8);
         bad = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 4 * n; i++) pl_q.push_back(8'($urandom));
         run_frame(8'(n), 8'h00, -1, bad, 1'b1, 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
